emblem_sequencer: RTL and testbench

EMBLEM_SEQUENCER -- requirements
Module: emblem_sequencer

---
 rtl/emblem_sequencer_pkg.sv | 49 ++++
 rtl/emblem_sequencer_bounce_axis.sv | 51 +++++
 rtl/emblem_sequencer.sv | 148 ++++++++++++++
 tb/tb_emblem_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/emblem_sequencer_pkg.sv
// Shared definitions for the emblem sequencer.
// Contents:
//   state_e          sequencer state encoding (IDLE..FADE_OUT, codes 5-7 unused)
//   LIMIT_X/LIMIT_Y  bounce offset limits in pixels
//   IDLE_FRAMES      frames spent in IDLE before fading in
//   CNT_W            width of the shared frame counter
//   bayer_threshold  4x4 ordered-dither threshold lookup
package emblem_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FADE_IN  = 3'd1,
    ST_HOLD     = 3'd2,
    ST_BOUNCE   = 3'd3,
    ST_FADE_OUT = 3'd4
  } state_e;

  localparam int LIMIT_X     = 80;
  localparam int LIMIT_Y     = 40;
  localparam int IDLE_FRAMES = 60;
  localparam int CNT_W       = 16;

  localparam logic [3:0] LEVEL_MAX = 4'd15;

  // Index is {y[1:0], x[1:0]}: row-major 4x4 Bayer matrix.
  function automatic logic [3:0] bayer_threshold(input logic [3:0] idx);
    logic [3:0] thr;
    case (idx)
      4'd0:    thr = 4'd0;
      4'd1:    thr = 4'd8;
      4'd2:    thr = 4'd2;
      4'd3:    thr = 4'd10;
      4'd4:    thr = 4'd12;
      4'd5:    thr = 4'd4;
      4'd6:    thr = 4'd14;
      4'd7:    thr = 4'd6;
      4'd8:    thr = 4'd3;
      4'd9:    thr = 4'd11;
      4'd10:   thr = 4'd1;
      4'd11:   thr = 4'd9;
      4'd12:   thr = 4'd15;
      4'd13:   thr = 4'd7;
      4'd14:   thr = 4'd13;
      default: thr = 4'd5;
    endcase
    return thr;
  endfunction

endpackage

// File: rtl/emblem_sequencer_bounce_axis.sv
// One bouncing offset axis.
// Ports:
//   clk, reset  pixel clock, synchronous active-high reset
//   clear_i     return offset to 0 and velocity to +1
//   step_i      advance offset by the current velocity (one frame)
//   off_o       signed offset, always within [-LIMIT, +LIMIT]
module bounce_axis #(
  parameter int LIMIT = 80
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              step_i,
  output logic signed [9:0] off_o
);

  localparam logic signed [9:0] POS_LIM = 10'(LIMIT);
  localparam logic signed [9:0] NEG_LIM = -POS_LIM;

  logic signed [9:0] off_q, off_d, off_nxt;
  logic              vel_neg_q, vel_neg_d;  // 1: moving toward -LIMIT

  assign off_nxt = off_q + (vel_neg_q ? -10'sd1 : 10'sd1);

  always_comb begin
    off_d     = off_q;
    vel_neg_d = vel_neg_q;
    if (clear_i) begin
      off_d     = '0;
      vel_neg_d = 1'b0;
    end else if (step_i) begin
      off_d = off_nxt;
      // Turn around on the frame the limit is reached so it is never passed.
      if (off_nxt == POS_LIM)      vel_neg_d = 1'b1;
      else if (off_nxt == NEG_LIM) vel_neg_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      off_q     <= '0;
      vel_neg_q <= 1'b0;
    end else begin
      off_q     <= off_d;
      vel_neg_q <= vel_neg_d;
    end
  end

  assign off_o = off_q;

endmodule

// File: rtl/emblem_sequencer.sv
// Emblem show sequencer: IDLE -> FADE_IN -> HOLD -> BOUNCE -> FADE_OUT -> IDLE.
// Fades the emblem with 4x4 ordered dither and bounces its position.
// Ports:
//   clk, reset          pixel clock, synchronous active-high reset
//   frame_start         one-cycle pulse per frame; paces all sequencing
//   btn_next            one-cycle pulse; jumps to the next state at once
//   x, y                current raster position
//   emblem_x, emblem_y  raster position translated by the bounce offset
//   emblem_draw_in      draw flag from the emblem overlay
//   emblem_gate         draw flag qualified by state and fade dither
//   state_o             current state code (debug)
module emblem_sequencer
  import emblem_sequencer_pkg::*;
#(
  parameter int HOLD_FRAMES      = 120,
  parameter int FADE_STEP_FRAMES = 4,
  parameter int BOUNCE_FRAMES    = 600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       btn_next,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [9:0] emblem_x,
  output logic [9:0] emblem_y,
  input  logic       emblem_draw_in,
  output logic       emblem_gate,
  output logic [2:0] state_o
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         level_q, level_d;
  logic               step, clear_off;
  logic signed [9:0]  off_x, off_y;
  logic [3:0]         threshold;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    step      = 1'b0;
    clear_off = 1'b0;
    if (state_q > ST_FADE_OUT) begin
      // Unused codes recover immediately, not on the next frame.
      state_d   = ST_IDLE;
      cnt_d     = '0;
      level_d   = '0;
      clear_off = 1'b1;
    end else if (btn_next) begin
      cnt_d = '0;
      case (state_q)
        ST_IDLE:     state_d = ST_FADE_IN;
        ST_FADE_IN:  begin state_d = ST_HOLD; level_d = LEVEL_MAX; end
        ST_HOLD:     state_d = ST_BOUNCE;
        ST_BOUNCE:   state_d = ST_FADE_OUT;
        default: begin
          state_d   = ST_IDLE;
          level_d   = '0;
          clear_off = 1'b1;
        end
      endcase
    end else if (frame_start) begin
      cnt_d = cnt_q + CNT_W'(1);
      case (state_q)
        ST_IDLE: begin
          level_d = '0;
          if (cnt_q == CNT_W'(IDLE_FRAMES - 1)) begin
            state_d = ST_FADE_IN;
            cnt_d   = '0;
          end
        end
        ST_FADE_IN: begin
          if (cnt_q == CNT_W'(FADE_STEP_FRAMES - 1)) begin
            cnt_d   = '0;
            level_d = level_q + 4'd1;
            if (level_q >= 4'd14) state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          level_d = LEVEL_MAX;
          if (cnt_q == CNT_W'(HOLD_FRAMES - 1)) begin
            state_d = ST_BOUNCE;
            cnt_d   = '0;
          end
        end
        ST_BOUNCE: begin
          step = 1'b1;
          if (cnt_q == CNT_W'(BOUNCE_FRAMES - 1)) begin
            state_d = ST_FADE_OUT;
            cnt_d   = '0;
          end
        end
        default: begin  // ST_FADE_OUT
          if (cnt_q == CNT_W'(FADE_STEP_FRAMES - 1)) begin
            cnt_d = '0;
            if (level_q <= 4'd1) begin
              level_d   = '0;
              state_d   = ST_IDLE;
              clear_off = 1'b1;
            end else begin
              level_d = level_q - 4'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  bounce_axis #(.LIMIT(LIMIT_X)) u_axis_x (
    .clk     (clk),
    .reset   (reset),
    .clear_i (clear_off),
    .step_i  (step),
    .off_o   (off_x)
  );

  bounce_axis #(.LIMIT(LIMIT_Y)) u_axis_y (
    .clk     (clk),
    .reset   (reset),
    .clear_i (clear_off),
    .step_i  (step),
    .off_o   (off_y)
  );

  // Modulo-1024 translation; wrap-around is intended.
  assign emblem_x = x - off_x;
  assign emblem_y = y - off_y;

  assign threshold   = bayer_threshold({y[1:0], x[1:0]});
  assign emblem_gate = emblem_draw_in && (state_q != ST_IDLE) &&
                       (state_q <= ST_FADE_OUT) && (level_q > threshold);
  assign state_o     = state_q;

endmodule

// File: tb/tb_emblem_sequencer.sv
module tb_emblem_sequencer;
  import emblem_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset, frame_start, btn_next, emblem_draw_in;
  logic [9:0] x, y, emblem_x, emblem_y;
  logic       emblem_gate;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;

  emblem_sequencer #(
    .HOLD_FRAMES      (10),
    .FADE_STEP_FRAMES (4),
    .BOUNCE_FRAMES    (300)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .frame_start    (frame_start),
    .btn_next       (btn_next),
    .x              (x),
    .y              (y),
    .emblem_x       (emblem_x),
    .emblem_y       (emblem_y),
    .emblem_draw_in (emblem_draw_in),
    .emblem_gate    (emblem_gate),
    .state_o        (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks: inputs change on negedge, outputs sampled on negedge
  task automatic pulse_frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) frame_start = 1'b1;
      @(negedge clk) frame_start = 1'b0;
    end
  endtask

  task automatic press_next(input logic with_frame);
    @(negedge clk);
    btn_next    = 1'b1;
    frame_start = with_frame;
    @(negedge clk);
    btn_next    = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int                gate_cnt;
  int                max_abs;
  int                a;
  logic signed [9:0] off_obs;

  initial begin
    reset = 1'b1; frame_start = 1'b0; btn_next = 1'b0;
    x = 10'd100; y = 10'd50; emblem_draw_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_ex", 32'(emblem_x), 32'd100);
    check("rst_ey", 32'(emblem_y), 32'd50);
    check("rst_gate", 32'(emblem_gate), 32'd0);

    // IDLE -> FADE_IN after exactly 60 frames
    pulse_frames(59);
    check("idle_59", 32'(state_o), 32'd0);
    pulse_frames(1);
    check("fade_in_enter", 32'(state_o), 32'd1);
    x = 10'd0; y = 10'd0; #1;
    check("fade_in_lvl0_gate", 32'(emblem_gate), 32'd0);

    // level 8: exactly 8 of 16 dither cells pass
    pulse_frames(32);
    gate_cnt = 0;
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++) begin
        x = 10'(i); y = 10'(j); #1;
        gate_cnt += int'(emblem_gate);
      end
    check("lvl8_tile_count", 32'(gate_cnt), 32'd8);
    x = 10'd1; y = 10'd0; #1;
    check("lvl8_thr8", 32'(emblem_gate), 32'd0);
    x = 10'd2; y = 10'd2; #1;
    check("lvl8_thr1", 32'(emblem_gate), 32'd1);
    @(negedge clk);

    // FADE_IN -> HOLD after 60 frames in FADE_IN
    pulse_frames(27);
    check("fade_in_59", 32'(state_o), 32'd1);
    pulse_frames(1);
    check("hold_enter", 32'(state_o), 32'd2);
    x = 10'd0; y = 10'd3; #1;
    check("lvl15_thr15", 32'(emblem_gate), 32'd0);
    x = 10'd1; y = 10'd3; #1;
    check("lvl15_thr7", 32'(emblem_gate), 32'd1);
    emblem_draw_in = 1'b0; #1;
    check("draw_off", 32'(emblem_gate), 32'd0);
    emblem_draw_in = 1'b1;
    x = 10'd100; y = 10'd50;
    @(negedge clk);

    // HOLD -> BOUNCE after 10 frames, no step on the transition frame
    pulse_frames(9);
    check("hold_9", 32'(state_o), 32'd2);
    pulse_frames(1);
    check("bounce_enter", 32'(state_o), 32'd3);
    check("bounce_enter_ex", 32'(emblem_x), 32'd100);

    // bounce trajectory
    max_abs = 0;
    for (int f = 1; f <= 240; f++) begin
      pulse_frames(1);
      off_obs = 10'd100 - emblem_x;
      a = int'(off_obs);
      if (a < 0) a = -a;
      if (a > max_abs) max_abs = a;
      if (f == 80) begin
        check("bx_f80", 32'(emblem_x), 32'd20);
        check("by_f80", 32'(emblem_y), 32'd50);
      end
      if (f == 81) begin
        check("bx_f81", 32'(emblem_x), 32'd21);
        check("by_f81", 32'(emblem_y), 32'd51);
      end
      if (f == 240) begin
        check("bx_f240", 32'(emblem_x), 32'd180);
        check("by_f240", 32'(emblem_y), 32'd50);
      end
    end
    check("bx_max_abs", 32'(max_abs), 32'd80);

    // BOUNCE -> FADE_OUT after 300 frames; offsets freeze
    pulse_frames(59);
    check("bounce_299", 32'(state_o), 32'd3);
    pulse_frames(1);
    check("fade_out_enter", 32'(state_o), 32'd4);
    check("fo_ex", 32'(emblem_x), 32'd120);
    check("fo_ey", 32'(emblem_y), 32'd70);
    pulse_frames(3);
    check("fo_ex_frozen", 32'(emblem_x), 32'd120);
    x = 10'd2; y = 10'd1; #1;
    check("fo_lvl15_thr14", 32'(emblem_gate), 32'd1);
    @(negedge clk);
    pulse_frames(1);
    check("fo_lvl14_thr14", 32'(emblem_gate), 32'd0);
    x = 10'd100; y = 10'd50;

    // btn_next from FADE_OUT -> IDLE, offsets cleared
    press_next(1'b0);
    check("btn_fo_idle", 32'(state_o), 32'd0);
    check("btn_fo_ex", 32'(emblem_x), 32'd100);
    check("btn_fo_ey", 32'(emblem_y), 32'd50);
    check("btn_fo_gate", 32'(emblem_gate), 32'd0);

    press_next(1'b0);
    check("btn_idle_fi", 32'(state_o), 32'd1);
    press_next(1'b0);
    check("btn_fi_hold", 32'(state_o), 32'd2);
    x = 10'd2; y = 10'd1; #1;
    check("btn_hold_lvl15", 32'(emblem_gate), 32'd1);
    x = 10'd100; y = 10'd50;

    // btn_next wins over simultaneous frame_start
    press_next(1'b1);
    check("btn_fs_state", 32'(state_o), 32'd3);
    check("btn_fs_cnt", 32'(dut.cnt_q), 32'd0);
    check("btn_fs_ex", 32'(emblem_x), 32'd100);

    // reset mid-bounce at off_x = +37
    pulse_frames(37);
    check("b37_ex", 32'(emblem_x), 32'd63);
    check("b37_ey", 32'(emblem_y), 32'd13);
    check("b37_gate", 32'(emblem_gate), 32'd1);
    @(negedge clk);
    reset = 1'b1; frame_start = 1'b1; btn_next = 1'b1;
    @(negedge clk);
    reset = 1'b0; frame_start = 1'b0; btn_next = 1'b0;
    check("rst_b_state", 32'(state_o), 32'd0);
    check("rst_b_ex", 32'(emblem_x), 32'd100);
    check("rst_b_gate", 32'(emblem_gate), 32'd0);

    // illegal state code recovers on the next clock
    force dut.state_q = state_e'(3'd6);
    #1;
    release dut.state_q;
    check("illegal_seen", 32'(state_o), 32'd6);
    @(negedge clk);
    check("illegal_recover", 32'(state_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
